// File: rtl/sys_defs.sv
// Shared system definitions: bus command encodings, instruction-cache geometry
// constants and the cache line entry type.
package sys_defs;

    localparam int XLEN = 32;

    typedef enum logic [1:0] {
        BUS_NONE = 2'd0,
        BUS_LOAD = 2'd1
    } bus_command_t;

    localparam int ICACHE_LINES_DEFAULT = 32;
    localparam int ICACHE_IDX_BITS      = $clog2(ICACHE_LINES_DEFAULT);
    localparam int ICACHE_TAG_BITS      = XLEN - 3 - ICACHE_IDX_BITS;
    // Stored tags are zero-extended to this width so any line count fits.
    localparam int ICACHE_TAG_MAX_BITS  = XLEN - 3;

    typedef struct packed {
        logic                           valid;
        logic [ICACHE_TAG_MAX_BITS-1:0] tag;
        logic [63:0]                    data;
    } ICACHE_ENTRY;

    typedef enum logic [1:0] {
        IC_IDLE = 2'd0,
        IC_REQ  = 2'd1,
        IC_WAIT = 2'd2
    } icache_state_t;

endpackage

// File: rtl/icache_mem.sv
// Instruction-cache line store: one asynchronous read port, one synchronous
// write port; only the valid bits are cleared by reset.
module icache_mem
    import sys_defs::*;
#(
    parameter int LINES = 32,
    parameter int IDX_W = $clog2(LINES)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [IDX_W-1:0] rd_idx,
    output ICACHE_ENTRY      rd_entry,
    input  logic             wr_en,
    input  logic [IDX_W-1:0] wr_idx,
    input  ICACHE_ENTRY      wr_entry
);

    logic [LINES-1:0]               valid_q;
    logic [ICACHE_TAG_MAX_BITS-1:0] tag_q  [LINES];
    logic [63:0]                    data_q [LINES];

    always_ff @(posedge clock) begin
        if (reset) begin
            valid_q <= '0;
        end else if (wr_en) begin
            valid_q[wr_idx] <= wr_entry.valid;
        end
    end

    always_ff @(posedge clock) begin
        if (wr_en) begin
            tag_q[wr_idx]  <= wr_entry.tag;
            data_q[wr_idx] <= wr_entry.data;
        end
    end

    always_comb begin
        rd_entry.valid = valid_q[rd_idx];
        rd_entry.tag   = tag_q[rd_idx];
        rd_entry.data  = data_q[rd_idx];
    end

endmodule

// File: rtl/icache.sv
// Direct-mapped, blocking instruction cache with a single outstanding miss.
// Optional feature macro ICACHE_PERF_EN adds hit/miss event counters.
module icache
    import sys_defs::*;
#(
    parameter int ICACHE_LINES = ICACHE_LINES_DEFAULT
) (
    input  logic            clock,
    input  logic            reset,
    input  logic [XLEN-1:0] proc2Icache_addr,
    output logic [63:0]     Icache2proc_data,
    output logic            Icache2proc_data_valid,
    output logic [1:0]      proc2Imem_command,
    output logic [XLEN-1:0] proc2Imem_addr,
    input  logic [3:0]      Imem2proc_response,
    input  logic [63:0]     Imem2proc_data,
    input  logic [3:0]      Imem2proc_tag
`ifdef ICACHE_PERF_EN
    ,
    output logic [31:0]     icache_hits,
    output logic [31:0]     icache_misses
`endif
);

    localparam int IDX_W  = $clog2(ICACHE_LINES);
    localparam int LINE_W = XLEN - 3;

    icache_state_t    state, next_state;
    logic [LINE_W-1:0] miss_line;
    logic [3:0]        pending_tag;

    logic [IDX_W-1:0]               cur_idx;
    logic [ICACHE_TAG_MAX_BITS-1:0] cur_tag;
    ICACHE_ENTRY                    rd_entry;
    ICACHE_ENTRY                    wr_entry;
    logic                           hit;
    logic                           fill;
    logic                           unused_offset;

    assign cur_idx       = proc2Icache_addr[3 +: IDX_W];
    assign cur_tag       = ICACHE_TAG_MAX_BITS'(proc2Icache_addr[XLEN-1:3+IDX_W]);
    assign hit           = rd_entry.valid && (rd_entry.tag == cur_tag);
    assign unused_offset = ^proc2Icache_addr[2:0];

    // Only the response tag we are waiting for completes the fill.
    assign fill = (state == IC_WAIT) && (pending_tag != 4'd0) &&
                  (Imem2proc_tag == pending_tag);

    always_comb begin
        wr_entry.valid = 1'b1;
        wr_entry.tag   = ICACHE_TAG_MAX_BITS'(miss_line[LINE_W-1:IDX_W]);
        wr_entry.data  = Imem2proc_data;
    end

    icache_mem #(
        .LINES (ICACHE_LINES),
        .IDX_W (IDX_W)
    ) u_mem (
        .clock    (clock),
        .reset    (reset),
        .rd_idx   (cur_idx),
        .rd_entry (rd_entry),
        .wr_en    (fill && !reset),
        .wr_idx   (miss_line[IDX_W-1:0]),
        .wr_entry (wr_entry)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            state       <= IC_IDLE;
            miss_line   <= '0;
            pending_tag <= 4'd0;
        end else begin
            state <= next_state;
            if (state == IC_IDLE && !hit) begin
                miss_line <= proc2Icache_addr[XLEN-1:3];
            end
            if (state == IC_REQ && Imem2proc_response != 4'd0) begin
                pending_tag <= Imem2proc_response;
            end else if (fill) begin
                pending_tag <= 4'd0;
            end
        end
    end

    always_comb begin
        next_state        = state;
        proc2Imem_command = BUS_NONE;
        proc2Imem_addr    = '0;
        case (state)
            IC_IDLE: begin
                if (!hit) next_state = IC_REQ;
            end
            IC_REQ: begin
                proc2Imem_command = BUS_LOAD;
                proc2Imem_addr    = {miss_line, 3'b000};
                if (Imem2proc_response != 4'd0) next_state = IC_WAIT;
            end
            IC_WAIT: begin
                if (fill) next_state = IC_IDLE;
            end
            default: next_state = IC_IDLE;
        endcase
        // Outputs are held quiet for the whole reset cycle.
        if (reset) begin
            proc2Imem_command = BUS_NONE;
            proc2Imem_addr    = '0;
        end
    end

    assign Icache2proc_data_valid = hit && !reset;
    assign Icache2proc_data       = Icache2proc_data_valid ? rd_entry.data : 64'd0;

`ifdef ICACHE_PERF_EN
    always_ff @(posedge clock) begin
        if (reset) begin
            icache_hits   <= 32'd0;
            icache_misses <= 32'd0;
        end else if (state == IC_IDLE) begin
            if (hit) icache_hits   <= icache_hits + 32'd1;
            else     icache_misses <= icache_misses + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_icache.sv
// Self-checking bench for icache: directed vector table plus randomized
// traffic compared against a line-level reference model.
module tb_icache;
    import sys_defs::*;

    logic            clock = 1'b0;
    logic            reset;
    logic [XLEN-1:0] addr;
    logic [63:0]     rdata;
    logic            rvalid;
    logic [1:0]      cmd;
    logic [XLEN-1:0] maddr;
    logic [3:0]      resp;
    logic [63:0]     mdata;
    logic [3:0]      mtag;
`ifdef ICACHE_PERF_EN
    logic [31:0]     hits;
    logic [31:0]     misses;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clock = ~clock;

    icache #(.ICACHE_LINES(32)) dut (
        .clock                  (clock),
        .reset                  (reset),
        .proc2Icache_addr       (addr),
        .Icache2proc_data       (rdata),
        .Icache2proc_data_valid (rvalid),
        .proc2Imem_command      (cmd),
        .proc2Imem_addr         (maddr),
        .Imem2proc_response     (resp),
        .Imem2proc_data         (mdata),
        .Imem2proc_tag          (mtag)
`ifdef ICACHE_PERF_EN
        ,
        .icache_hits            (hits),
        .icache_misses          (misses)
`endif
    );

    task automatic check(input string name, input int idx, input logic [63:0] got,
                         input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s @%0d: got 0x%0h required 0x%0h", name, idx, got, exp);
        end
    endtask

    typedef struct {
        logic        rst;
        logic [31:0] a;
        logic [3:0]  rsp;
        logic [3:0]  tg;
        logic [63:0] d;
        logic        ev;
        logic [63:0] ed;
        logic [1:0]  ec;
        logic [31:0] ea;
    } vec_t;

    localparam logic [63:0] D1 = 64'hDEADBEEF_00000013;
    localparam logic [63:0] D2 = 64'h11112222_33334444;
    localparam logic [63:0] D3 = 64'hAAAABBBB_CCCCDDDD;
    localparam logic [1:0]  NO = BUS_NONE;
    localparam logic [1:0]  LD = BUS_LOAD;

    vec_t vecs[$];

    // Reference model state: per-line contents and the miss in flight.
    bit          m_valid [32];
    int unsigned m_tag   [32];
    logic [63:0] m_data  [32];
    int          m_phase;   // 0 none outstanding, 1 requesting, 2 awaiting data
    int unsigned m_line;
    logic [3:0]  m_pend;

    task automatic model_reset();
        foreach (m_valid[i]) m_valid[i] = 0;
        m_phase = 0;
        m_pend  = 4'd0;
        m_line  = 0;
    endtask

    initial begin
        // Cold miss, then hit on the same line at a different word offset
        vecs.push_back('{1, 32'h100, 0, 0, 0, 0, 0, NO, 0});
        vecs.push_back('{0, 32'h100, 0, 0, 0, 0, 0, NO, 0});
        vecs.push_back('{0, 32'h100, 0, 0, 0, 0, 0, LD, 32'h100});
        vecs.push_back('{0, 32'h100, 3, 0, 0, 0, 0, LD, 32'h100});
        vecs.push_back('{0, 32'h100, 0, 0, 0, 0, 0, NO, 0});
        vecs.push_back('{0, 32'h100, 0, 0, 0, 0, 0, NO, 0});
        vecs.push_back('{0, 32'h100, 0, 3, D1, 0, 0, NO, 0});
        vecs.push_back('{0, 32'h100, 0, 0, 0, 1, D1, NO, 0});
        vecs.push_back('{0, 32'h104, 0, 0, 0, 1, D1, NO, 0});
        // Rejected request held for four cycles
        vecs.push_back('{0, 32'h40C, 0, 0, 0, 0, 0, NO, 0});
        for (int i = 0; i < 4; i++)
            vecs.push_back('{0, 32'h40C, 0, 0, 0, 0, 0, LD, 32'h408});
        vecs.push_back('{0, 32'h40C, 5, 0, 0, 0, 0, LD, 32'h408});
        vecs.push_back('{0, 32'h40C, 0, 0, 0, 0, 0, NO, 0});
        vecs.push_back('{0, 32'h40C, 0, 5, D2, 0, 0, NO, 0});
        vecs.push_back('{0, 32'h40C, 0, 0, 0, 1, D2, NO, 0});
        // Address change mid-miss, with a stray tag while waiting
        vecs.push_back('{0, 32'h200, 0, 0, 0, 0, 0, NO, 0});
        vecs.push_back('{0, 32'h200, 2, 0, 0, 0, 0, LD, 32'h200});
        vecs.push_back('{0, 32'h300, 0, 0, 0, 0, 0, NO, 0});
        vecs.push_back('{0, 32'h300, 0, 7, 64'h77, 0, 0, NO, 0});
        vecs.push_back('{0, 32'h300, 0, 2, D3, 0, 0, NO, 0});
        vecs.push_back('{0, 32'h300, 0, 0, 0, 0, 0, NO, 0});
        vecs.push_back('{0, 32'h300, 1, 0, 0, 0, 0, LD, 32'h300});
        vecs.push_back('{0, 32'h200, 0, 0, 0, 1, D3, NO, 0});
        // Reset while waiting; the old tag must not fill anything
        vecs.push_back('{1, 32'h100, 0, 0, 0, 0, 0, NO, 0});
        vecs.push_back('{0, 32'h100, 0, 1, 64'h55, 0, 0, NO, 0});
        vecs.push_back('{0, 32'h200, 0, 0, 0, 0, 0, LD, 32'h100});

        reset = 1'b1; addr = '0; resp = '0; mdata = '0; mtag = '0;
        foreach (vecs[i]) begin
            reset = vecs[i].rst;
            addr  = vecs[i].a;
            resp  = vecs[i].rsp;
            mtag  = vecs[i].tg;
            mdata = vecs[i].d;
            @(negedge clock);
            check("dir_valid", i, 64'(rvalid), 64'(vecs[i].ev));
            check("dir_data",  i, rdata,       vecs[i].ed);
            check("dir_cmd",   i, 64'(cmd),    64'(vecs[i].ec));
            check("dir_maddr", i, 64'(maddr),  64'(vecs[i].ea));
            @(posedge clock);
            #1;
        end

        // Randomized traffic against the reference model
        reset = 1'b1;
        model_reset();
        @(posedge clock); #1;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            logic [3:0]  r_resp, r_tag;
            logic [31:0] r_addr;
            logic [63:0] r_data;
            int unsigned line, idx, tg;
            bit          hit, r_rst;
            r_rst  = ($urandom_range(0, 99) == 0);
            r_addr = ($urandom_range(0, 3) << 8) | ($urandom_range(0, 3) << 3) |
                     $urandom_range(0, 7);
            r_resp = ($urandom_range(0, 1) == 0) ? 4'd0 : 4'($urandom_range(1, 15));
            r_tag  = ($urandom_range(0, 2) == 0) ? m_pend : 4'($urandom_range(0, 15));
            r_data = {$urandom, $urandom};
            reset = r_rst; addr = r_addr; resp = r_resp; mtag = r_tag; mdata = r_data;

            line = r_addr >> 3;
            idx  = line % 32;
            tg   = r_addr >> 8;
            hit  = m_valid[idx] && (m_tag[idx] == tg) && !r_rst;
            @(negedge clock);
            check("rnd_valid", cyc, 64'(rvalid), 64'(hit));
            check("rnd_data",  cyc, rdata, hit ? m_data[idx] : 64'd0);
            check("rnd_cmd",   cyc, 64'(cmd),
                  64'((m_phase == 1 && !r_rst) ? BUS_LOAD : BUS_NONE));
            check("rnd_maddr", cyc, 64'(maddr),
                  (m_phase == 1 && !r_rst) ? 64'(m_line * 8) : 64'd0);

            if (r_rst) begin
                model_reset();
            end else if (m_phase == 0) begin
                if (!hit) begin m_line = line; m_phase = 1; end
            end else if (m_phase == 1) begin
                if (r_resp != 0) begin m_pend = r_resp; m_phase = 2; end
            end else begin
                if (m_pend != 0 && r_tag == m_pend) begin
                    m_valid[m_line % 32] = 1;
                    m_tag[m_line % 32]   = m_line / 32;
                    m_data[m_line % 32]  = r_data;
                    m_pend  = 4'd0;
                    m_phase = 0;
                end
            end
            @(posedge clock);
            #1;
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/icache.md
ICACHE -- requirements
Module: icache

Interface
REQ-001 SHALL have parameter ICACHE_LINES, default 32, number of direct-mapped 8-byte lines (power of 2).
REQ-002 SHALL have port clock, input, 1, system clock, with all state updated on its rising edge.
REQ-003 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-004 SHALL have port proc2Icache_addr, input, XLEN, fetch address from fetch; bits [2:0] ignored.
REQ-005 SHALL have port Icache2proc_data, output, 64, line data for proc2Icache_addr.
REQ-006 SHALL have port Icache2proc_data_valid, output, 1, Icache2proc_data is valid this cycle.
REQ-007 SHALL have port proc2Imem_command, output, 2, BUS_NONE or BUS_LOAD.
REQ-008 SHALL have port proc2Imem_addr, output, XLEN, line address, bits [2:0] zero.
REQ-009 SHALL have port Imem2proc_response, input, 4, memory tag accepting a request (0 = rejected).
REQ-010 SHALL have port Imem2proc_data, input, 64, returning line data.
REQ-011 SHALL have port Imem2proc_tag, input, 4, tag of Imem2proc_data (0 = no data).

Function
REQ-012 SHALL split the address as index = addr[3 +: log2(ICACHE_LINES)] and tag = addr[XLEN-1 : 3+log2(ICACHE_LINES)].
REQ-013 SHALL assert Icache2proc_data_valid combinationally in the same cycle on a hit (line valid and stored tag equal), driving the stored line on Icache2proc_data.
REQ-014 SHALL drive Icache2proc_data_valid 0 and Icache2proc_data 0 on a miss.
REQ-015 SHALL use FSM states IDLE, REQ, WAIT.
REQ-016 IDLE: on a miss, latch the miss line address and go to REQ; on a hit, stay in IDLE.
REQ-017 REQ: drive BUS_LOAD with the latched line address every cycle; when Imem2proc_response != 0, latch it as pending tag and go to WAIT; otherwise stay in REQ.
REQ-018 WAIT: drive BUS_NONE; when Imem2proc_tag == pending tag and pending tag != 0, write Imem2proc_data, tag, and valid=1 into the latched index, clear pending tag, and go to IDLE.
REQ-019 SHALL drive proc2Imem_command BUS_NONE in IDLE and WAIT.
REQ-020 SHALL NOT abandon an outstanding miss on an address change; the fill completes into the originally latched line.
REQ-021 SHALL re-evaluate hit/miss against the current proc2Icache_addr the cycle after a fill (one-cycle fill-to-hit latency; no same-cycle forwarding).
REQ-022 SHALL ignore any Imem2proc_tag not equal to the pending tag, including in IDLE and REQ.
REQ-023 SHALL support at most one outstanding miss.

Reset
REQ-024 SHALL, on reset, clear all line valid bits, enter IDLE, clear the pending tag, and drive Icache2proc_data_valid=0, Icache2proc_data=0, proc2Imem_command=BUS_NONE, and proc2Imem_addr=0.
REQ-025 SHALL, on reset mid-miss, drop the outstanding request, so that a later matching Imem2proc_tag writes nothing.

Configuration
REQ-026 SHALL, with ICACHE_PERF_EN defined, add 32-bit outputs icache_hits and icache_misses, where icache_hits increments each IDLE cycle with a hit, icache_misses increments on each IDLE-to-REQ transition, both wrap at 2^32, and both reset to 0.
REQ-027 SHALL, without ICACHE_PERF_EN, have neither those ports nor counter logic.

Structure
REQ-028 SHALL place BUS_NONE/BUS_LOAD encodings, the ICACHE_TAG_BITS/ICACHE_IDX_BITS constants, and the ICACHE_ENTRY typedef (valid, tag, 64-bit data) in the shared sys_defs package.
REQ-029 SHALL implement the line store as sub-module icache_mem (one async-read port, one sync-write port, reset-cleared valid bits).

Verification
REQ-030 SHALL cover a cold miss: after reset, addr=0x100, response=3 in cycle 2, tag=3 with data 0xDEADBEEF_00000013 in cycle 5 -> BUS_LOAD at 0x100 in cycles 1-2, valid=1 with that data in cycle 6.
REQ-031 SHALL cover a hit after fill: re-present 0x104 -> valid=1 the same cycle, same 64-bit data, command BUS_NONE.
REQ-032 SHALL cover a rejected request: response=0 for 4 cycles, then 5 -> BUS_LOAD held with a stable address for all 5 cycles, then WAIT.
REQ-033 SHALL cover an address change mid-miss: miss on 0x200, addr switched to 0x300 in WAIT, tag returns -> line for 0x200 filled, valid=0, and a new miss issued for 0x300.
REQ-034 SHALL cover a stray tag: tag=7 while pending=2 -> no fill, stays in WAIT.
REQ-035 SHALL cover reset in WAIT, followed by the pending tag arriving -> no fill, and 0x100 misses again.
